mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter BADDR, default 2, byte-offset bits of the address.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid and ready are both high at a clock edge.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size_i  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-009 SHALL have port req_unsigned_i  input  1  zero-extend loads when high, sign-extend when low.
REQ-010 SHALL have port req_addr_i  input  XLEN  byte address.
REQ-011 SHALL have port req_wdata_i  input  XLEN  store data, right-aligned.
REQ-012 SHALL have port rsp_valid_o  output  1  response valid.
REQ-013 SHALL have port rsp_ready_i  input  1  response consumed when valid and ready are both high at a clock edge.
REQ-014 SHALL have port rsp_rdata_o  output  XLEN  extended load data; 0 for stores.
REQ-015 SHALL have port rsp_err_o  output  1  misaligned access flag.
REQ-016 SHALL have ports mem_gwe_o, mem_rd_o, mem_bw0_o..mem_bw3_o  output  1 each  memory word-write, read and byte-write strobes.
REQ-017 SHALL have ports mem_addr_o  output  XLEN, mem_data_o  output  XLEN, mem_data_i  input  XLEN  (memory read data, registered, valid one cycle after mem_rd_o).

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, WAIT, RESP; req_ready_o high only in IDLE.
REQ-019 SHALL, on acceptance in IDLE, register the whole request and go to ISSUE (or to RESP on a trapped misalignment, per REQ-032).
REQ-020 SHALL assert the memory strobes for exactly the single ISSUE cycle; all strobes are 0 in every other state.
REQ-021 SHALL drive mem_addr_o from the registered address, held from ISSUE through the end of the transaction.
REQ-022 SHALL, for a word store, assert mem_gwe_o with mem_data_o = wdata.
REQ-023 SHALL, for a byte store at offset b, assert only mem_bw<b>_o with mem_data_o[7:0] = wdata[7:0] and upper bits 0.
REQ-024 SHALL, for a half store at offset 00, assert bw0 and bw1; at offset 10, assert bw2 and bw3; mem_data_o[15:0] = wdata[15:0], upper bits 0.
REQ-025 SHALL, for stores, go ISSUE -> RESP, giving rsp_valid_o 2 cycles after acceptance.
REQ-026 SHALL, for loads, assert mem_rd_o in ISSUE, go ISSUE -> WAIT, capture mem_data_i at the end of WAIT, then go to RESP, giving rsp_valid_o 3 cycles after acceptance.
REQ-027 SHALL extract byte b of a load from mem_data_i[8b+7:8b]; a half at offset 00 from [15:0] and at offset 10 from [31:16]; then extend per req_unsigned_i.
REQ-028 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i is high, then return to IDLE.
REQ-029 SHALL not accept a new request in the cycle a response is consumed; the earliest acceptance is the following cycle.

Reset
REQ-030 SHALL, while rst_ni is low, immediately force IDLE, deassert every strobe and rsp_valid_o, and set rsp_rdata_o, rsp_err_o, mem_addr_o and mem_data_o to 0.
REQ-031 SHALL, on reset in mid-transaction, drop the in-flight access with no response; a strobe already sampled by the memory is not undone.

Configuration
REQ-032 SHALL, with MISALIGN_TRAP_EN defined, detect misalignment (half at offset 01 or 11; word at any offset other than 00), issue no memory strobes, go IDLE -> RESP, and respond with rsp_err_o = 1 and rsp_rdata_o = 0.
REQ-033 SHALL, without MISALIGN_TRAP_EN, clear addr[0] for halves and addr[1:0] for words, perform the access normally, and tie rsp_err_o to 0.

Verification
REQ-034 SHALL verify: word store 0xDEADBEEF to 0x40000010 -> mem_gwe_o for one cycle, mem_data_o = 0xDEADBEEF, rsp_valid_o 2 cycles after acceptance.
REQ-035 SHALL verify: signed byte load at 0x40000013 with mem_data_i = 0x80FF7F01 -> rsp_rdata_o = 0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-036 SHALL verify: half store 0x1234ABCD to 0x40000012 -> bw2 and bw3 only, mem_data_o = 0x0000ABCD.
REQ-037 SHALL verify: word load at 0x40000006 -> with the macro, no strobes and rsp_err_o = 1; without it, mem_addr_o = 0x40000004 and rsp_err_o = 0.
REQ-038 SHALL verify: rsp_ready_i held low for 5 cycles -> response held stable and req_ready_o low; then ready high -> IDLE the next cycle.
REQ-039 SHALL verify: rst_ni pulsed low during WAIT -> strobes 0 and rsp_valid_o 0 asynchronously, and a new request is accepted after release.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between a valid/ready request port
// and a strobed word memory. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_lsu #(
  parameter int XLEN  = 32,
  parameter int BADDR = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_gwe_o,
  output logic            mem_rd_o,
  output logic            mem_bw0_o,
  output logic            mem_bw1_o,
  output logic            mem_bw2_o,
  output logic            mem_bw3_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_o,
  input  logic [XLEN-1:0] mem_data_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t            state;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [BADDR-1:0]  off_q;
  logic              gwe_q, rd_q, rsp_valid_q, err_q;
  logic [3:0]        bw_q;
  logic [XLEN-1:0]   rdata_q, addr_q, wdata_q;

  logic [1:0]        size_in;
  logic [3:0]        bw_in;
  logic [XLEN-1:0]   addr_al, wfmt, ld_ext;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic              trap;

  // Request decode: alignment, right-aligned store data and byte strobes.
  always_comb begin
    size_in = (req_size_i == 2'b11) ? SZ_W : req_size_i;
    addr_al = req_addr_i;
    wfmt    = req_wdata_i;
    bw_in   = 4'b0000;
    case (size_in)
      SZ_B: begin
        wfmt  = {{(XLEN-8){1'b0}}, req_wdata_i[7:0]};
        bw_in = 4'b0001 << req_addr_i[BADDR-1:0];
      end
      SZ_H: begin
        addr_al[0] = 1'b0;
        wfmt       = {{(XLEN-16){1'b0}}, req_wdata_i[15:0]};
        bw_in      = req_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: addr_al[BADDR-1:0] = '0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = ((size_in == SZ_H) && req_addr_i[0]) ||
                ((size_in == SZ_W) && (req_addr_i[BADDR-1:0] != '0));
`else
  assign trap = 1'b0;
`endif

  assign ld_b = mem_data_i[{off_q, 3'b000} +: 8];
  assign ld_h = mem_data_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    ld_ext = uns_q ? {{(XLEN-8){1'b0}}, ld_b}  : {{(XLEN-8){ld_b[7]}}, ld_b};
      SZ_H:    ld_ext = uns_q ? {{(XLEN-16){1'b0}}, ld_h} : {{(XLEN-16){ld_h[15]}}, ld_h};
      default: ld_ext = mem_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= '0;
      gwe_q       <= 1'b0;
      rd_q        <= 1'b0;
      bw_q        <= 4'b0000;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Strobes live for exactly the ISSUE cycle.
      gwe_q <= 1'b0;
      rd_q  <= 1'b0;
      bw_q  <= 4'b0000;
      case (state)
        IDLE: if (req_valid_i) begin
          we_q    <= req_we_i;
          uns_q   <= req_unsigned_i;
          size_q  <= size_in;
          off_q   <= addr_al[BADDR-1:0];
          addr_q  <= addr_al;
          wdata_q <= req_we_i ? wfmt : '0;
          if (trap) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= '0;
          end else begin
            state <= ISSUE;
            gwe_q <= req_we_i && (size_in == SZ_W);
            rd_q  <= !req_we_i;
            bw_q  <= req_we_i ? bw_in : 4'b0000;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b0;
            rdata_q     <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          err_q       <= 1'b0;
          rdata_q     <= ld_ext;
        end
        RESP: if (rsp_ready_i) begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_gwe_o   = gwe_q;
  assign mem_rd_o    = rd_q;
  assign mem_bw0_o   = bw_q[0];
  assign mem_bw1_o   = bw_q[1];
  assign mem_bw2_o   = bw_q[2];
  assign mem_bw3_o   = bw_q[3];
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors for mem_lsu with a one-cycle registered memory model.
module tb_mem_lsu;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0, rsp_ready_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, mem_data_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic        mem_gwe_o, mem_rd_o, mem_bw0_o, mem_bw1_o, mem_bw2_o, mem_bw3_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_data_o;
  logic [31:0] ld_word = '0;

  int checks = 0;
  int errors = 0;

  // Observations from the last transaction.
  int          lat, gwe_n, rd_n, bw_n;
  logic [3:0]  bw_or;
  logic [31:0] dat, adr, rdata;
  logic        err;

  wire [3:0] bw = {mem_bw3_o, mem_bw2_o, mem_bw1_o, mem_bw0_o};
  wire [5:0] strb = {mem_gwe_o, mem_rd_o, bw};

  mem_lsu #(.XLEN(32), .BADDR(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_gwe_o(mem_gwe_o), .mem_rd_o(mem_rd_o),
    .mem_bw0_o(mem_bw0_o), .mem_bw1_o(mem_bw1_o), .mem_bw2_o(mem_bw2_o), .mem_bw3_o(mem_bw3_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Registered read port: data appears the cycle after mem_rd_o, zero otherwise.
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) mem_data_i <= '0;
    else         mem_data_i <= mem_rd_o ? ld_word : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input logic [31:0] exp_rd);
    @(negedge clk_i);
    chk("ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 0; gwe_n = 0; rd_n = 0; bw_n = 0; bw_or = '0; dat = '0; adr = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) adr = mem_addr_o;
      if (mem_gwe_o) gwe_n++;
      if (mem_rd_o) rd_n++;
      if (|bw) bw_n++;
      bw_or |= bw;
      if (mem_gwe_o || (|bw)) dat = mem_data_o;
      if (rsp_valid_o) begin
        lat = k + 1;
        break;
      end
      @(negedge clk_i);
    end
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
    chk("ready_in_resp", {31'b0, req_ready_o}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("hold_rdata", rsp_rdata_o, exp_rd);
      chk("hold_ready", {31'b0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("back_idle", {31'b0, req_ready_o}, 32'd1);
    chk("rsp_dropped", {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_strb",  {26'b0, strb}, 32'd0);
    chk("rst_rvld",  {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, 32'd0);
    chk("rst_data",  mem_data_o, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err",   {31'b0, rsp_err_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Word store
    txn(1'b1, 2'b10, 1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 0, 32'h0);
    chk("sw_gwe",   gwe_n, 1);
    chk("sw_bw",    bw_n, 0);
    chk("sw_data",  dat, 32'hDEAD_BEEF);
    chk("sw_addr",  adr, 32'h4000_0010);
    chk("sw_lat",   lat, 2);
    chk("sw_rdata", rdata, 32'h0);

    // Signed / unsigned byte load at offset 3
    ld_word = 32'h80FF_7F01;
    txn(1'b0, 2'b00, 1'b0, 32'h4000_0013, 32'h0, 0, 32'h0);
    chk("lb_rd",    rd_n, 1);
    chk("lb_lat",   lat, 3);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_addr",  adr, 32'h4000_0013);
    txn(1'b0, 2'b00, 1'b1, 32'h4000_0013, 32'h0, 0, 32'h0);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    txn(1'b0, 2'b00, 1'b0, 32'h4000_0011, 32'h0, 0, 32'h0);
    chk("lb1_rdata", rdata, 32'h0000_007F);
    txn(1'b0, 2'b01, 1'b0, 32'h4000_0002, 32'h0, 0, 32'h0);
    chk("lh2_rdata", rdata, 32'hFFFF_80FF);
    txn(1'b0, 2'b01, 1'b1, 32'h4000_0000, 32'h0, 0, 32'h0);
    chk("lhu0_rdata", rdata, 32'h0000_7F01);

    // Half store at offset 2
    txn(1'b1, 2'b01, 1'b0, 32'h4000_0012, 32'h1234_ABCD, 0, 32'h0);
    chk("sh_bw",   {28'b0, bw_or}, 32'hC);
    chk("sh_bwn",  bw_n, 1);
    chk("sh_gwe",  gwe_n, 0);
    chk("sh_data", dat, 32'h0000_ABCD);

    // Byte store at offset 1
    txn(1'b1, 2'b00, 1'b0, 32'h4000_0001, 32'hAABB_CC55, 0, 32'h0);
    chk("sb_bw",   {28'b0, bw_or}, 32'h2);
    chk("sb_data", dat, 32'h0000_0055);
    chk("sb_lat",  lat, 2);

    // Size 11 behaves as a word store
    txn(1'b1, 2'b11, 1'b0, 32'h4000_0020, 32'h0102_0304, 0, 32'h0);
    chk("s11_gwe",  gwe_n, 1);
    chk("s11_data", dat, 32'h0102_0304);

    // Misaligned word load
    ld_word = 32'h1122_3344;
    txn(1'b0, 2'b10, 1'b0, 32'h4000_0006, 32'h0, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_rd",    rd_n, 0);
    chk("mis_bw",    bw_n + gwe_n, 0);
    chk("mis_err",   {31'b0, err}, 32'd1);
    chk("mis_rdata", rdata, 32'h0);
    chk("mis_lat",   lat, 1);
`else
    chk("mis_addr",  adr, 32'h4000_0004);
    chk("mis_err",   {31'b0, err}, 32'd0);
    chk("mis_rd",    rd_n, 1);
    chk("mis_rdata", rdata, 32'h1122_3344);
`endif

    // Backpressure: response held for 5 cycles
    ld_word = 32'hCAFE_F00D;
    txn(1'b0, 2'b10, 1'b0, 32'h4000_0008, 32'h0, 5, 32'hCAFE_F00D);
    chk("bp_rdata", rdata, 32'hCAFE_F00D);

    // Reset during ISSUE of a store: strobe cleared without a clock edge
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10;
    req_addr_i = 32'h4000_0030; req_wdata_i = 32'h5555_AAAA;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("ri_gwe_pre", {31'b0, mem_gwe_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ri_gwe", {31'b0, mem_gwe_o}, 32'd0);
    chk("ri_data", mem_data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset during WAIT of a load
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10;
    req_addr_i = 32'h4000_0040;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rw_addr_pre", mem_addr_o, 32'h4000_0040);
    #2 rst_ni = 1'b0;
    #1;
    chk("rw_strb", {26'b0, strb}, 32'd0);
    chk("rw_rvld", {31'b0, rsp_valid_o}, 32'd0);
    chk("rw_addr", mem_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rw_no_rsp", {31'b0, rsp_valid_o}, 32'd0);

    // New request after release
    ld_word = 32'h0BAD_F00D;
    txn(1'b0, 2'b10, 1'b0, 32'h4000_0044, 32'h0, 0, 32'h0);
    chk("post_rdata", rdata, 32'h0BAD_F00D);
    chk("post_lat",   lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
